// File: rtl/cv32e40p_pkg.sv
// Shared definitions for the interrupt source controller register port:
// byte offsets of each register and the word-index enum decoded from addr[4:2].
package cv32e40p_pkg;

    localparam logic [4:0] IRQ_PENDING_OFS = 5'h00;
    localparam logic [4:0] IRQ_ENABLE_OFS  = 5'h04;
    localparam logic [4:0] IRQ_EDGE_OFS    = 5'h08;
    localparam logic [4:0] IRQ_SET_OFS     = 5'h0C;
    localparam logic [4:0] IRQ_ACTIVE_OFS  = 5'h10;
    localparam logic [4:0] IRQ_LASTID_OFS  = 5'h14;

    typedef enum logic [2:0] {
        IRQ_REG_PENDING = IRQ_PENDING_OFS[4:2],
        IRQ_REG_ENABLE  = IRQ_ENABLE_OFS[4:2],
        IRQ_REG_EDGE    = IRQ_EDGE_OFS[4:2],
        IRQ_REG_SET     = IRQ_SET_OFS[4:2],
        IRQ_REG_ACTIVE  = IRQ_ACTIVE_OFS[4:2],
        IRQ_REG_LASTID  = IRQ_LASTID_OFS[4:2],
        IRQ_REG_RSVD0   = 3'd6,
        IRQ_REG_RSVD1   = 3'd7
    } irq_reg_e;

endpackage

// File: rtl/cv32e40p_irq_src_sync.sv
// Per-line two-flop synchronizer for asynchronous peripheral interrupt lines.
// Both stages clear on the synchronous active-low reset.
module cv32e40p_irq_src_sync #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/cv32e40p_irq_source_ctrl.sv
// Interrupt source controller driving the core irq_i vector: edge/level pending
// latches, software enable mask and a zero-wait register port. Optional input
// synchronizer enabled by defining CV32E40P_IRQ_SRC_SYNC_EN.
module cv32e40p_irq_source_ctrl
    import cv32e40p_pkg::*;
#(
    parameter int          NUM_IRQ    = 32,
    parameter logic [31:0] ENABLE_RST = 32'h0,
    parameter logic [31:0] EDGE_RST   = 32'hFFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] irq_src_i,
    output logic [31:0] irq_o,
    input  logic        irq_ack_i,
    input  logic [4:0]  irq_id_i,
    input  logic        reg_sel_i,
    input  logic        reg_we_i,
    input  logic [3:0]  reg_be_i,
    input  logic [4:0]  reg_addr_i,
    input  logic [31:0] reg_wdata_i,
    output logic [31:0] reg_rdata_o
);

    // Mask of source lines below NUM_IRQ.
    localparam logic [31:0] IRQ_MASK = 32'hFFFF_FFFF >> (32 - NUM_IRQ);

    logic [31:0] src;
    logic [31:0] src_q;
    logic [31:0] pending_q;
    logic [31:0] enable_q;
    logic [31:0] edge_q;
    logic [31:0] lastid_q;

    logic [31:0] wmask;
    logic [31:0] wbits;
    logic        wr_en;
    irq_reg_e    word;
    logic [31:0] set_vec;
    logic [31:0] clr_vec;
    logic [31:0] pending_nxt;
    wire         unused_addr = ^reg_addr_i[1:0];

`ifdef CV32E40P_IRQ_SRC_SYNC_EN
    logic [31:0] src_sync;

    cv32e40p_irq_src_sync #(
        .WIDTH (32)
    ) u_src_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (irq_src_i),
        .q_o    (src_sync)
    );

    assign src = src_sync & IRQ_MASK;
`else
    assign src = irq_src_i & IRQ_MASK;
`endif

    assign wmask = {{8{reg_be_i[3]}}, {8{reg_be_i[2]}}, {8{reg_be_i[1]}}, {8{reg_be_i[0]}}};
    assign wbits = reg_wdata_i & wmask & IRQ_MASK;
    assign wr_en = reg_sel_i & reg_we_i;
    assign word  = irq_reg_e'(reg_addr_i[4:2]);

    always_comb begin
        set_vec = src & ~src_q;
        clr_vec = '0;
        if (wr_en && word == IRQ_REG_SET) begin
            set_vec = set_vec | wbits;
        end
        if (wr_en && word == IRQ_REG_PENDING) begin
            clr_vec = wbits;
        end
        if (irq_ack_i && (32'(irq_id_i) < NUM_IRQ)) begin
            clr_vec = clr_vec | (32'h1 << irq_id_i);
        end
        // Set wins over a simultaneous clear; level lines simply follow the source.
        pending_nxt = ((edge_q & (set_vec | (pending_q & ~clr_vec))) | (~edge_q & src)) & IRQ_MASK;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            src_q     <= '0;
            pending_q <= '0;
            enable_q  <= ENABLE_RST & IRQ_MASK;
            edge_q    <= EDGE_RST & IRQ_MASK;
            lastid_q  <= '0;
        end else begin
            src_q     <= src;
            pending_q <= pending_nxt;
            if (wr_en && word == IRQ_REG_ENABLE) begin
                enable_q <= (enable_q & ~wmask) | wbits;
            end
            if (wr_en && word == IRQ_REG_EDGE) begin
                edge_q <= (edge_q & ~wmask) | wbits;
            end
            if (irq_ack_i) begin
                lastid_q <= {1'b1, 26'd0, irq_id_i};
            end
        end
    end

    assign irq_o = pending_q & enable_q & IRQ_MASK;

    always_comb begin
        reg_rdata_o = '0;
        if (reg_sel_i && !reg_we_i) begin
            case (word)
                IRQ_REG_PENDING: reg_rdata_o = pending_q;
                IRQ_REG_ENABLE:  reg_rdata_o = enable_q;
                IRQ_REG_EDGE:    reg_rdata_o = edge_q;
                IRQ_REG_ACTIVE:  reg_rdata_o = pending_q & enable_q;
                IRQ_REG_LASTID:  reg_rdata_o = lastid_q;
                default:         reg_rdata_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cv32e40p_irq_source_ctrl.sv
// Directed-vector bench for cv32e40p_irq_source_ctrl with hand-computed expectations.
module tb_cv32e40p_irq_source_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [31:0] irq_src_i;
    logic [31:0] irq_o;
    logic        irq_ack_i;
    logic [4:0]  irq_id_i;
    logic        reg_sel_i;
    logic        reg_we_i;
    logic [3:0]  reg_be_i;
    logic [4:0]  reg_addr_i;
    logic [31:0] reg_wdata_i;
    logic [31:0] reg_rdata_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cv32e40p_irq_source_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .irq_src_i   (irq_src_i),
        .irq_o       (irq_o),
        .irq_ack_i   (irq_ack_i),
        .irq_id_i    (irq_id_i),
        .reg_sel_i   (reg_sel_i),
        .reg_we_i    (reg_we_i),
        .reg_be_i    (reg_be_i),
        .reg_addr_i  (reg_addr_i),
        .reg_wdata_i (reg_wdata_i),
        .reg_rdata_o (reg_rdata_o)
    );

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] be);
        reg_sel_i   = 1'b1;
        reg_we_i    = 1'b1;
        reg_addr_i  = addr;
        reg_wdata_i = data;
        reg_be_i    = be;
        tick();
        reg_sel_i   = 1'b0;
        reg_we_i    = 1'b0;
        reg_wdata_i = '0;
        reg_be_i    = '0;
    endtask

    task automatic reg_read(input logic [4:0] addr, output logic [31:0] data);
        reg_sel_i  = 1'b1;
        reg_we_i   = 1'b0;
        reg_addr_i = addr;
        #1;
        data = reg_rdata_o;
        reg_sel_i  = 1'b0;
        reg_addr_i = '0;
    endtask

    task automatic ack(input logic [4:0] id);
        irq_ack_i = 1'b1;
        irq_id_i  = id;
        tick();
        irq_ack_i = 1'b0;
        irq_id_i  = '0;
    endtask

    logic [31:0] rd;

    initial begin
        rst_ni      = 1'b0;
        irq_src_i   = '0;
        irq_ack_i   = 1'b0;
        irq_id_i    = '0;
        reg_sel_i   = 1'b0;
        reg_we_i    = 1'b0;
        reg_be_i    = '0;
        reg_addr_i  = '0;
        reg_wdata_i = '0;
        tick();
        tick();
        check_vec("rst_irq", irq_o, 32'h0);
        rst_ni = 1'b1;
        tick();
        reg_read(5'h04, rd); check_vec("rst_enable", rd, 32'h0);
        reg_read(5'h08, rd); check_vec("rst_edge", rd, 32'hFFFF_FFFF);
        reg_read(5'h00, rd); check_vec("rst_pending", rd, 32'h0);
        check_vec("rdata_unsel", reg_rdata_o, 32'h0);

`ifndef CV32E40P_IRQ_SRC_SYNC_EN
        // Edge line 11: one-cycle pulse, then acked.
        reg_write(5'h04, 32'h0000_0800, 4'hF);
        irq_src_i[11] = 1'b1;
        tick();
        irq_src_i[11] = 1'b0;
        check_vec("edge11_irq", irq_o, 32'h0000_0800);
        tick();
        check_vec("edge11_hold", irq_o, 32'h0000_0800);
        ack(5'd11);
        check_vec("edge11_ack", irq_o, 32'h0);
        reg_read(5'h14, rd); check_vec("lastid11", rd, 32'h8000_000B);

        // Level line 3 ignores ack and SET, follows source.
        reg_write(5'h08, 32'hFFFF_FFF7, 4'hF);
        reg_write(5'h04, 32'h0000_0808, 4'hF);
        irq_src_i[3] = 1'b1;
        tick();
        check_vec("lvl3_on", irq_o, 32'h0000_0008);
        ack(5'd3);
        check_vec("lvl3_ack", irq_o, 32'h0000_0008);
        irq_src_i[3] = 1'b0;
        tick();
        check_vec("lvl3_drop", irq_o, 32'h0);
        reg_write(5'h0C, 32'h0000_0008, 4'hF);
        check_vec("lvl3_set", irq_o, 32'h0);

        // Edge line 5: new rising edge coinciding with its ack.
        reg_write(5'h04, 32'h0000_0020, 4'hF);
        irq_src_i[5] = 1'b1;
        tick();
        irq_src_i[5] = 1'b0;
        check_vec("edge5_on", irq_o, 32'h0000_0020);
        tick();
        irq_src_i[5] = 1'b1;
        ack(5'd5);
        irq_src_i[5] = 1'b0;
        check_vec("edge5_setwins", irq_o, 32'h0000_0020);
        ack(5'd5);
        check_vec("edge5_clr", irq_o, 32'h0);
        reg_read(5'h14, rd); check_vec("lastid5", rd, 32'h8000_0005);

        // SET with partial byte enables, W1C, reserved offsets.
        reg_write(5'h0C, 32'h8000_0001, 4'b0001);
        reg_read(5'h00, rd); check_vec("set_be", rd, 32'h0000_0001);
        reg_write(5'h04, 32'hFFFF_FFFF, 4'hF);
        check_vec("set_irq", irq_o, 32'h0000_0001);
        reg_read(5'h10, rd); check_vec("active", rd, 32'h0000_0001);
        reg_read(5'h0C, rd); check_vec("set_reads0", rd, 32'h0);
        reg_write(5'h00, 32'h0000_0001, 4'hF);
        reg_read(5'h00, rd); check_vec("w1c", rd, 32'h0);
        reg_read(5'h18, rd); check_vec("rsvd18", rd, 32'h0);
        reg_write(5'h1C, 32'h0000_0000, 4'hF);
        reg_read(5'h04, rd); check_vec("rsvd1c_wr", rd, 32'hFFFF_FFFF);
        reg_write(5'h04, 32'h0000_0000, 4'b0010);
        reg_read(5'h04, rd); check_vec("enable_be", rd, 32'hFFFF_00FF);

        // Disable keeps pending; mid-operation reset discards it.
        reg_write(5'h0C, 32'h0000_0100, 4'hF);
        check_vec("set8_irq", irq_o, 32'h0);
        reg_write(5'h04, 32'h0000_0000, 4'hF);
        reg_write(5'h0C, 32'h0000_0200, 4'hF);
        check_vec("disable_mask", irq_o, 32'h0);
        reg_read(5'h00, rd); check_vec("disable_pend", rd, 32'h0000_0300);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        reg_read(5'h00, rd); check_vec("rst2_pending", rd, 32'h0);
        reg_read(5'h14, rd); check_vec("rst2_lastid", rd, 32'h0);
        reg_read(5'h08, rd); check_vec("rst2_edge", rd, 32'hFFFF_FFFF);
`else
        // Synchronized path: three cycles from source rise to irq_o.
        reg_write(5'h04, 32'h0000_0080, 4'hF);
        irq_src_i[7] = 1'b1;
        tick();
        check_vec("sync_c1", irq_o, 32'h0);
        tick();
        check_vec("sync_c2", irq_o, 32'h0);
        tick();
        check_vec("sync_c3", irq_o, 32'h0000_0080);
        irq_src_i = '0;
        rst_ni = 1'b0;
        tick();
        check_vec("sync_rst_irq", irq_o, 32'h0);
        check_vec("sync_rst_meta", dut.u_src_sync.meta_q, 32'h0);
        check_vec("sync_rst_sync", dut.u_src_sync.sync_q, 32'h0);
        reg_read(5'h00, rd); check_vec("sync_rst_pend", rd, 32'h0);
        rst_ni = 1'b1;
        tick();
        tick();
        tick();
        check_vec("sync_post_rst", irq_o, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cv32e40p_irq_source_ctrl.md
Name: cv32e40p_irq_source_ctrl

Overview:
Interrupt source controller on the responder side of the core's interrupt interface. It drives the core's irq_i vector and consumes irq_ack_o/irq_id_o. It latches peripheral interrupt lines as edge- or level-sensitive pending bits and masks them with a software enable. Software configures it over a single-cycle, zero-wait-state register port with the same signal set as the core's data memory interface.

Parameters:
NUM_IRQ, 32, number of implemented source lines (1..32); bits at or above NUM_IRQ are tied 0 everywhere.
ENABLE_RST, 32'h0, reset value of the ENABLE register.
EDGE_RST, 32'hFFFF_FFFF, reset value of the EDGE register (1 = rising-edge, 0 = level).

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
irq_src_i  in  32  peripheral interrupt lines, synchronous to clk_i unless the optional feature is on
irq_o  out  32  to core irq_i; pending & enable
irq_ack_i  in  1  from core irq_ack_o; 1-cycle pulse
irq_id_i  in  5  from core irq_id_o; line being taken
reg_sel_i  in  1  register port chip select
reg_we_i  in  1  write enable
reg_be_i  in  4  byte enables
reg_addr_i  in  5  byte address; bits [4:2] select the word
reg_wdata_i  in  32  write data
reg_rdata_o  out  32  read data, combinational from flops

Behaviour:
- Register map (word offset):
  - 0x00 PENDING: read; write-1-to-clear, edge lines only.
  - 0x04 ENABLE: RW.
  - 0x08 EDGE: RW.
  - 0x0C SET: write-1-to-set pending, edge lines only; reads 0.
  - 0x10 ACTIVE: RO, pending & enable.
  - 0x14 LASTID: RO; [4:0] last acked id, [31] = ack seen since reset.
  - Offsets 0x18/0x1C read 0; writes to them are ignored.
- Writes occur only when reg_sel_i & reg_we_i, per byte lane as gated by reg_be_i. Reads (reg_sel_i & ~reg_we_i) return data in the same cycle. reg_rdata_o = 0 when reg_sel_i = 0.
- Reset (rst_ni = 0 at a clock edge):
  - pending = 0, src_q = 0, ENABLE = ENABLE_RST, EDGE = EDGE_RST, LASTID = 0.
  - Therefore irq_o = 0 and reg_rdata_o = 0.
  - Reset mid-operation discards all pending state.
- Edge line i (EDGE[i] = 1):
  - set_i = irq_src_i[i] & ~src_q[i], OR a SET write with bit i = 1.
  - clr_i = W1C with bit i = 1, OR irq_ack_i & (irq_id_i == i).
  - Next pending[i] = set_i | (pending[i] & ~clr_i). Set wins over a simultaneous clear.
- Level line i (EDGE[i] = 0):
  - Next pending[i] = irq_src_i[i]. SET, W1C and ack have no effect.
- src_q <= irq_src_i every cycle.
- irq_o = pending_q & ENABLE_q, masked to NUM_IRQ bits. No combinational path from any input.
- Latency: source rise at edge k sets pending at edge k. irq_o is high in the cycle after edge k, i.e. 1 cycle.
- Acks:
  - irq_id_i >= NUM_IRQ: ignored for pending, still recorded in LASTID.
  - An ack for a disabled or non-pending line is harmless.
  - LASTID updates on every irq_ack_i.
- Changing EDGE on a line takes effect next cycle. Edge→level makes pending track the source. Level→edge keeps the current pending value.
- Clearing ENABLE masks irq_o next cycle and leaves pending untouched.

Optional Feature:
- Macro CV32E40P_IRQ_SRC_SYNC_EN.
- Defined: a 2-flop synchronizer is inserted on irq_src_i before edge detection and level sampling. Latency becomes 3 cycles. The synchronizer flops reset to 0.
- Undefined: irq_src_i is used directly and latency is 1 cycle.

Decomposition:
- cv32e40p_pkg gets:
  - register offset localparams IRQ_PENDING_OFS..IRQ_LASTID_OFS;
  - the typedef irq_reg_e for the word index.
- One sub-module, cv32e40p_irq_src_sync: a per-line 2-flop synchronizer, instantiated only under the macro.

Test Plan:
- Reset → irq_o = 0. ENABLE reads 0. EDGE reads 32'hFFFF_FFFF. PENDING reads 0.
- Write ENABLE = 32'h0000_0800; pulse irq_src_i[11] for 1 cycle → irq_o = 32'h0000_0800 next cycle. Ack id 11 → irq_o = 0 next cycle, LASTID = 32'h8000_000B.
- Set EDGE[3] = 0, ENABLE[3] = 1; hold irq_src_i[3] high → irq_o[3] stays 1 across an ack of id 3. Drop the source → irq_o[3] = 0 one cycle later.
- Edge line 5 enabled: a new rising edge on source 5 in the same cycle as the ack of id 5 → pending[5] stays 1 and irq_o[5] stays 1.
- Write SET = 32'h8000_0001 with be = 4'b0001 → only pending[0] is set. W1C PENDING with 32'h1 → pending[0] cleared. Read of 0x18 → 0.
- With the macro defined: source 7 rise → irq_o[7] rises exactly 3 cycles later. Assert rst_ni = 0 while pending → all pending, irq_o and synchronizer flops are 0 after the reset edge.
